gecko_decode_scoreboard: RTL
============================

Name: gecko_decode_scoreboard

Overview:
- Parametrised register scoreboard for the gecko decode stage.
- Replaces the binary per-register valid/full status with per-register in-flight write counters.
- Supports NUM_WB_PORTS concurrent writebacks and tracks the execute-forwarded register (exec_saved) internally.
- Decode issues through a valid/ready handshake. The block answers the operand hazard query combinationally and updates counters on issue and writeback.

Parameters:
- NUM_REGS, 32: number of architectural registers. Index 0 is hardwired and never tracked.
- ADDR_WIDTH, 5: register address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS.
- COUNTER_WIDTH, 2: per-register in-flight counter width. Max outstanding writes per register is CNT_MAX = 2^COUNTER_WIDTH-1.
- NUM_WB_PORTS, 2: number of independent writeback/retire ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it (combinational)
- issue_rs1  in  ADDR_WIDTH  source 1 address
- issue_rs2  in  ADDR_WIDTH  source 2 address
- issue_rd  in  ADDR_WIDTH  destination address
- issue_rs1_used  in  1  instruction reads rs1
- issue_rs2_used  in  1  instruction reads rs2
- issue_rd_used  in  1  instruction writes rd
- issue_kind  in  2  gecko_sb_issue_kind_t: NONE, EXEC_RESULT, CLOBBER
- issue_no_forward  in  1  operands must not use the execute path (system/env ops)
- rs1_reuse  out  1  rs1 is sourced from the execute path
- rs2_reuse  out  1  rs2 is sourced from the execute path
- wb_valid  in  NUM_WB_PORTS  per-port writeback strobe
- wb_addr  in  NUM_WB_PORTS*ADDR_WIDTH  per-port writeback address
- flush  in  1  pipeline flush
- exec_saved  out  ADDR_WIDTH  current execute-saved register
- underflow_err  out  1  sticky: a writeback hit a zero counter
- stat_stall_cycles  out  32  see Optional Feature
- stat_issued  out  32  see Optional Feature

Behaviour:
- Reset (async assert, sync release): all counters 0, exec_saved=0, underflow_err=0, stats 0.
- Status per register r: VALID when cnt=0; PENDING when 0<cnt<CNT_MAX; FULL when cnt=CNT_MAX. Register 0 is always VALID.
- readable(a): a==0, or cnt[a]==0, or (!issue_no_forward && a==exec_saved && exec_saved!=0 && cnt[a]==1).
- writeable(rd): rd==0 or cnt[rd]<CNT_MAX.
- issue_ready = (!rs1_used | readable(rs1)) & (!rs2_used | readable(rs2)) & (!rd_used | writeable(rd)).
  - issue_ready does not depend on issue_valid or on same-cycle writebacks.
  - Zero-latency combinational path.
- rsN_reuse = rsN_used & rsN!=0 & rsN==exec_saved & !issue_no_forward.
- fire = issue_valid & issue_ready.
- Counter update each cycle, per r!=0:
  - inc = fire & rd_used & rd==r
  - dec = number of wb ports with valid and addr==r
  - next = cnt + inc - dec
  - Duplicate writeback ports to the same r both decrement.
- Underflow: if dec > cnt+inc, the counter saturates at 0 and underflow_err sets. It stays set until reset.
- Overflow cannot occur because issue_ready blocks it. A simultaneous wb to a FULL register does not unblock the same cycle.
- exec_saved updates on fire only:
  - EXEC_RESULT with rd_used: exec_saved <= rd.
  - CLOBBER: exec_saved <= 0 if exec_saved==rd, else unchanged.
  - NONE: unchanged.
- flush: exec_saved <= 0, taking priority over a same-cycle fire update. Counters are unaffected, since in-flight ops still write back. Issue is still legal in the flush cycle.
- Writebacks to address 0 are ignored and never raise underflow.

Optional Feature:
- Macro: GECKO_SCOREBOARD_STATS_EN.
- When defined:
  - stat_stall_cycles increments each cycle with issue_valid & !issue_ready.
  - stat_issued increments on each fire.
  - Both wrap at 2^32 and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package gecko adds:
  - gecko_sb_issue_kind_t, a 2-bit enum.
  - Counter-to-status helper function gecko_sb_status(cnt, max) returning gecko_reg_status_t.
- Package gecko_decode_util adds a helper mapping rv32_fields_t to issue_kind/used flags, so decode drives the ports.
- Sub-module gecko_scoreboard_counter: one saturating up/down counter with inc, dec-count input, underflow flag and status output. Instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
- Reset then issue rd=5 EXEC_RESULT -> cnt[5]=1, exec_saved=5. Next instruction reading rs1=5 gets issue_ready=1 and rs1_reuse=1.
- COUNTER_WIDTH=2: three issues to rd=7 with no wb -> cnt=3 (FULL). Fourth issue to rd=7 gets issue_ready=0 and stat_stall_cycles increments. wb_addr[0]=7 -> next cycle ready=1.
- Same cycle: fire rd=3 with cnt[3]=1, plus wb ports 0 and 1 both addr=3 -> cnt[3]=0, underflow_err=0. Repeating the double wb at cnt=0 -> underflow_err=1, cnt stays 0.
- exec_saved=9, CLOBBER issue rd=9 -> exec_saved=0. A subsequent read of x9 with cnt=2 stalls until two writebacks.
- flush asserted with a simultaneous EXEC_RESULT fire rd=4 -> exec_saved=0, cnt[4]=1.
- issue_no_forward=1 reading rs1=exec_saved=6 with cnt[6]=1 -> issue_ready=0 and rs1_reuse=0. After wb 6, ready=1.

Source files
------------

// File: rtl/gecko_decode_scoreboard_pkg.sv
// Shared types and helpers for the gecko decode-stage register scoreboard.
// Issue-kind and register-status enums, the counter-to-status helper and a
// decode helper that maps RV32 instruction fields onto the scoreboard's
// issue-side control inputs.
package gecko_decode_scoreboard_pkg;

   // How a fired instruction affects the execute-saved register
   typedef enum logic [1:0] {
      SB_KIND_NONE        = 2'd0,
      SB_KIND_EXEC_RESULT = 2'd1,
      SB_KIND_CLOBBER     = 2'd2
   } gecko_sb_issue_kind_t;

   // Per-register availability derived from the in-flight write counter
   typedef enum logic [1:0] {
      REG_VALID   = 2'd0,
      REG_PENDING = 2'd1,
      REG_FULL    = 2'd2
   } gecko_reg_status_t;

   // Counter values are zero-extended into this width before classification
   localparam int SB_STATUS_ARG_WIDTH = 16;

   function automatic gecko_reg_status_t gecko_sb_status(
      input logic [SB_STATUS_ARG_WIDTH-1:0] cnt,
      input logic [SB_STATUS_ARG_WIDTH-1:0] max
   );
      gecko_reg_status_t st;
      if (cnt == 16'd0) begin
         st = REG_VALID;
      end else if (cnt >= max) begin
         st = REG_FULL;
      end else begin
         st = REG_PENDING;
      end
      return st;
   endfunction

   // Raw RV32 instruction fields as seen by decode
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rv32_fields_t;

   // Scoreboard issue controls produced by decode
   typedef struct packed {
      gecko_sb_issue_kind_t kind;
      logic                 rs1_used;
      logic                 rs2_used;
      logic                 rd_used;
      logic                 no_forward;
   } gecko_sb_issue_ctrl_t;

   localparam logic [6:0] RV32_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] RV32_OP_IMM    = 7'b0010011;
   localparam logic [6:0] RV32_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] RV32_OP_STORE  = 7'b0100011;
   localparam logic [6:0] RV32_OP_REG    = 7'b0110011;
   localparam logic [6:0] RV32_OP_LUI    = 7'b0110111;
   localparam logic [6:0] RV32_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] RV32_OP_JALR   = 7'b1100111;
   localparam logic [6:0] RV32_OP_JAL    = 7'b1101111;
   localparam logic [6:0] RV32_OP_SYSTEM = 7'b1110011;

   // Loads and system ops produce results outside the execute path, so they
   // clobber the execute-saved register instead of becoming it.
   function automatic gecko_sb_issue_ctrl_t gecko_sb_decode_issue(input rv32_fields_t f);
      gecko_sb_issue_ctrl_t c;
      c.kind       = SB_KIND_NONE;
      c.rs1_used   = 1'b0;
      c.rs2_used   = 1'b0;
      c.rd_used    = 1'b0;
      c.no_forward = 1'b0;
      case (f.opcode)
         RV32_OP_REG: begin
            c.kind = SB_KIND_EXEC_RESULT;
            c.rs1_used = 1'b1; c.rs2_used = 1'b1; c.rd_used = 1'b1;
         end
         RV32_OP_IMM, RV32_OP_JALR: begin
            c.kind = SB_KIND_EXEC_RESULT;
            c.rs1_used = 1'b1; c.rd_used = 1'b1;
         end
         RV32_OP_LUI, RV32_OP_AUIPC, RV32_OP_JAL: begin
            c.kind = SB_KIND_EXEC_RESULT;
            c.rd_used = 1'b1;
         end
         RV32_OP_LOAD: begin
            c.kind = SB_KIND_CLOBBER;
            c.rs1_used = 1'b1; c.rd_used = 1'b1;
         end
         RV32_OP_STORE, RV32_OP_BRANCH: begin
            c.rs1_used = 1'b1; c.rs2_used = 1'b1;
         end
         RV32_OP_SYSTEM: begin
            c.kind = SB_KIND_CLOBBER;
            c.rs1_used = 1'b1; c.rd_used = 1'b1; c.no_forward = 1'b1;
         end
         default: begin
            c.kind = SB_KIND_NONE;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/gecko_scoreboard_counter.sv
// One per-register in-flight write counter: +1 on issue, -dec_i on writeback,
// saturating at zero with a one-cycle underflow indication.
module gecko_scoreboard_counter
   import gecko_decode_scoreboard_pkg::*;
#(
   parameter int COUNTER_WIDTH = 2,
   parameter int DEC_WIDTH     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     inc_i,
   input  logic [DEC_WIDTH-1:0]     dec_i,
   output logic [COUNTER_WIDTH-1:0] cnt_o,
   output gecko_reg_status_t        status_o,
   output logic                     underflow_o
);

   localparam int SUM_WIDTH = ((COUNTER_WIDTH > DEC_WIDTH) ? COUNTER_WIDTH : DEC_WIDTH) + 1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

   logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
   logic [SUM_WIDTH-1:0]     up_s, dec_s, diff_s;
   logic                     underflow_s;

   // Next count; more writebacks than outstanding writes clamps to zero
   always_comb begin
      up_s        = SUM_WIDTH'(cnt_q) + SUM_WIDTH'(inc_i);
      dec_s       = SUM_WIDTH'(dec_i);
      diff_s      = '0;
      cnt_d       = cnt_q;
      underflow_s = 1'b0;
      if (dec_s > up_s) begin
         cnt_d       = '0;
         underflow_s = 1'b1;
      end else begin
         diff_s = up_s - dec_s;
         // Issue is blocked at CNT_MAX, so this clamp only guards misuse
         if (diff_s > SUM_WIDTH'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
         end else begin
            cnt_d = diff_s[COUNTER_WIDTH-1:0];
         end
      end
   end

   // Counter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign status_o    = gecko_sb_status(SB_STATUS_ARG_WIDTH'(cnt_q), SB_STATUS_ARG_WIDTH'(CNT_MAX));
   assign underflow_o = underflow_s;

endmodule

// File: rtl/gecko_decode_scoreboard.sv
// gecko decode-stage register scoreboard with per-register in-flight write
// counters, multi-port writeback and execute-path forwarding tracking.
// Optional issue/stall statistics: define GECKO_SCOREBOARD_STATS_EN.
module gecko_decode_scoreboard
   import gecko_decode_scoreboard_pkg::*;
#(
   parameter int NUM_REGS      = 32,
   parameter int ADDR_WIDTH    = 5,
   parameter int COUNTER_WIDTH = 2,
   parameter int NUM_WB_PORTS  = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               issue_valid,
   output logic                               issue_ready,
   input  logic [ADDR_WIDTH-1:0]              issue_rs1,
   input  logic [ADDR_WIDTH-1:0]              issue_rs2,
   input  logic [ADDR_WIDTH-1:0]              issue_rd,
   input  logic                               issue_rs1_used,
   input  logic                               issue_rs2_used,
   input  logic                               issue_rd_used,
   input  logic [1:0]                         issue_kind,
   input  logic                               issue_no_forward,
   output logic                               rs1_reuse,
   output logic                               rs2_reuse,
   input  logic [NUM_WB_PORTS-1:0]            wb_valid,
   input  logic [NUM_WB_PORTS*ADDR_WIDTH-1:0] wb_addr,
   input  logic                               flush,
   output logic [ADDR_WIDTH-1:0]              exec_saved,
   output logic                               underflow_err,
   output logic [31:0]                        stat_stall_cycles,
   output logic [31:0]                        stat_issued
);

   localparam int DEC_WIDTH  = $clog2(NUM_WB_PORTS + 1);
   localparam int ADDR_SPACE = 1 << ADDR_WIDTH;

   // Index 0 and addresses at or above NUM_REGS read as an idle counter
   logic [COUNTER_WIDTH-1:0] cnt_s    [ADDR_SPACE];
   gecko_reg_status_t        status_s [ADDR_SPACE];
   logic [ADDR_SPACE-1:0]    uf_s;

   logic                     fire_s;
   logic                     rdy_s;
   logic                     rs1_ok_s, rs2_ok_s, rd_ok_s;
   logic [COUNTER_WIDTH-1:0] cnt_rs1_s, cnt_rs2_s;
   logic [ADDR_WIDTH-1:0]    exec_saved_q, exec_saved_d;
   logic                     underflow_q, underflow_d;
   gecko_sb_issue_kind_t     kind_s;

   assign kind_s = gecko_sb_issue_kind_t'(issue_kind);
   assign fire_s = issue_valid & rdy_s;

   for (genvar r = 0; r < ADDR_SPACE; r++) begin : g_reg
      if (r >= 1 && r < NUM_REGS) begin : g_trk
         logic [DEC_WIDTH-1:0] dec_s;
         logic                 inc_s;

         assign inc_s = fire_s & issue_rd_used & (issue_rd == ADDR_WIDTH'(r));

         // Count writeback ports targeting this register; duplicates all count
         always_comb begin
            dec_s = '0;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
               if (wb_valid[p] && (wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
                  dec_s = dec_s + DEC_WIDTH'(1);
               end else begin
                  dec_s = dec_s;
               end
            end
         end

         gecko_scoreboard_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .DEC_WIDTH     (DEC_WIDTH)
         ) u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (inc_s),
            .dec_i       (dec_s),
            .cnt_o       (cnt_s[r]),
            .status_o    (status_s[r]),
            .underflow_o (uf_s[r])
         );
      end else begin : g_untracked
         assign cnt_s[r]    = '0;
         assign status_s[r] = REG_VALID;
         assign uf_s[r]     = 1'b0;
      end
   end

   // Operand hazard query: sources readable, destination not saturated
   always_comb begin
      cnt_rs1_s = cnt_s[issue_rs1];
      cnt_rs2_s = cnt_s[issue_rs2];
      rs1_ok_s  = 1'b1;
      rs2_ok_s  = 1'b1;
      rd_ok_s   = 1'b1;
      if (issue_rs1_used) begin
         rs1_ok_s = (issue_rs1 == '0) || (cnt_rs1_s == '0) ||
                    (!issue_no_forward && (issue_rs1 == exec_saved_q) &&
                     (exec_saved_q != '0) && (cnt_rs1_s == COUNTER_WIDTH'(1)));
      end else begin
         rs1_ok_s = 1'b1;
      end
      if (issue_rs2_used) begin
         rs2_ok_s = (issue_rs2 == '0) || (cnt_rs2_s == '0) ||
                    (!issue_no_forward && (issue_rs2 == exec_saved_q) &&
                     (exec_saved_q != '0) && (cnt_rs2_s == COUNTER_WIDTH'(1)));
      end else begin
         rs2_ok_s = 1'b1;
      end
      if (issue_rd_used) begin
         rd_ok_s = (issue_rd == '0) || (status_s[issue_rd] != REG_FULL);
      end else begin
         rd_ok_s = 1'b1;
      end
      rdy_s = rs1_ok_s & rs2_ok_s & rd_ok_s;
   end

   assign issue_ready = rdy_s;
   assign rs1_reuse   = issue_rs1_used & (issue_rs1 != '0) & (issue_rs1 == exec_saved_q) & !issue_no_forward;
   assign rs2_reuse   = issue_rs2_used & (issue_rs2 != '0) & (issue_rs2 == exec_saved_q) & !issue_no_forward;

   // Execute-saved tracking; flush wins over a same-cycle fire
   always_comb begin
      exec_saved_d = exec_saved_q;
      if (flush) begin
         exec_saved_d = '0;
      end else if (fire_s) begin
         case (kind_s)
            SB_KIND_EXEC_RESULT: begin
               if (issue_rd_used) begin
                  exec_saved_d = issue_rd;
               end else begin
                  exec_saved_d = exec_saved_q;
               end
            end
            SB_KIND_CLOBBER: begin
               if (exec_saved_q == issue_rd) begin
                  exec_saved_d = '0;
               end else begin
                  exec_saved_d = exec_saved_q;
               end
            end
            SB_KIND_NONE: exec_saved_d = exec_saved_q;
            default:      exec_saved_d = exec_saved_q;
         endcase
      end else begin
         exec_saved_d = exec_saved_q;
      end
   end

   // Sticky underflow accumulates any counter's clamp event
   always_comb begin
      underflow_d = underflow_q | (|uf_s);
   end

   // Execute-saved and error state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_saved_q <= '0;
         underflow_q  <= 1'b0;
      end else begin
         exec_saved_q <= exec_saved_d;
         underflow_q  <= underflow_d;
      end
   end

   assign exec_saved    = exec_saved_q;
   assign underflow_err = underflow_q;

`ifdef GECKO_SCOREBOARD_STATS_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] issued_q, issued_d;

   // Free-running wrap-around statistics
   always_comb begin
      stall_d  = stall_q;
      issued_d = issued_q;
      if (issue_valid && !rdy_s) begin
         stall_d = stall_q + 32'd1;
      end else begin
         stall_d = stall_q;
      end
      if (fire_s) begin
         issued_d = issued_q + 32'd1;
      end else begin
         issued_d = issued_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q  <= 32'd0;
         issued_q <= 32'd0;
      end else begin
         stall_q  <= stall_d;
         issued_q <= issued_d;
      end
   end

   assign stat_stall_cycles = stall_q;
   assign stat_issued       = issued_q;
`else
   assign stat_stall_cycles = 32'd0;
   assign stat_issued       = 32'd0;
`endif

endmodule
